apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB slave stage that sits directly downstream of the team's APB master.
- Consumes psel/penable/pwrite/padd/pwdata and returns pr_data/pready.
- Backs the bus with an internal register memory and inserts a programmable number of wait states per transfer.
- Serves as the bus endpoint for master bring-up and as a reusable memory-mapped scratch block.

Parameters:
- ADDR_W, 8, width of padd.
- DATA_W, 8, width of pwdata/pr_data.
- DEPTH, 256, number of DATA_W-bit words; valid addresses are 0..DEPTH-1 (DEPTH <= 2**ADDR_W).
- WAIT_STATES, 0, extra ACCESS cycles before pready asserts (0..15).

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- psel  input  1  slave select from master.
- penable  input  1  access-phase strobe from master.
- pwrite  input  1  1 = write, 0 = read.
- padd  input  ADDR_W  transfer address.
- pwdata  input  DATA_W  write data.
- pr_data  output  DATA_W  read data, registered.
- pready  output  1  transfer-complete strobe.
- pslverr  output  1  error response; valid only while pready=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, pr_data=0, pslverr=0, pready=0.
  - Memory contents are not reset; they are undefined until written.
  - Reset during ACCESS aborts the transfer and commits no write.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS at an edge with psel=1 and penable=0 (setup phase). On that edge:
    - cnt <= WAIT_STATES.
    - For a read, pr_data <= mem[padd]. For an invalid read address, pr_data <= 0.
  - In IDLE, penable=1 without a preceding setup is a protocol violation: ignore it and keep pready=0.
  - ACCESS with psel=1, penable=1, cnt!=0: cnt decrements by 1 each cycle; pready=0.
  - ACCESS with psel=1, penable=1, cnt==0: pready=1 combinationally from state/cnt/psel/penable. At this edge:
    - A write commits mem[padd] <= pwdata, unless the address is invalid.
    - The FSM returns to IDLE.
  - ACCESS with psel=0: abort to IDLE; no write, pready stays 0.
- Latency:
  - Zero-wait transfer = 2 cycles (setup + 1 access).
  - With WAIT_STATES=N, pready asserts in access cycle N+1.
- pr_data holds its value until the next read setup; write transfers leave it unchanged.
- Back-to-back transfers: the slave is in IDLE on the cycle after completion, so a master setup there is accepted with no bubble.
- Addresses and data are sampled at the edge where they are used: padd at setup for reads, padd/pwdata at the completing edge for writes. The master holds them stable per APB.
- Write and read of the same address in consecutive transfers: the read returns the newly written data, because the write commits before the next setup edge.
- pready is asserted only when state=ACCESS, psel=1, penable=1 and cnt==0, never otherwise.

Optional Feature:
- Macro: APB_SLAVE_PSLVERR_EN.
- Defined:
  - Address >= DEPTH is invalid.
  - pslverr=1 together with pready in the completing cycle.
  - Writes to invalid addresses are dropped; reads return 0.
- Not defined:
  - pslverr is tied to 0.
  - Address is wrapped as padd mod DEPTH; all accesses succeed.
- The port is present in both builds.

Decomposition:
- Package apb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - State encoding constants APB_S_IDLE=1'b0, APB_S_ACCESS=1'b1.
  - MAX_WAIT=15.
- One natural sub-module, apb_reg_mem:
  - DEPTH x DATA_W array.
  - Synchronous write port (we, waddr, wdata).
  - Synchronous read-capture port (re, raddr, rdata).
- FSM and wait counter stay in apb_slave_mem.

Test Plan:
- Zero-wait write: WAIT_STATES=0; setup psel=1 pwrite=1 padd=0xab pwdata=0xcd, then penable=1 -> pready=1 in the first access cycle; mem[0xab]=0xcd.
- Read-back: read setup padd=0xab followed by access -> pr_data=0xcd with pready=1 in the first access cycle; back-to-back with the preceding write, no idle cycle.
- Wait states: WAIT_STATES=2; write 0x5a to 0x10 -> pready=0 for 2 access cycles, pready=1 on the 3rd; write committed only at that edge.
- Error (APB_SLAVE_PSLVERR_EN defined, DEPTH=128): write 0x77 to 0xcd -> pready=1 with pslverr=1, no memory change. Read 0xcd -> pr_data=0x00, pslverr=1. Macro undefined: the same write lands at 0x4d, pslverr=0.
- Abort/reset:
  - psel dropped mid-ACCESS (WAIT_STATES=3) -> FSM returns to IDLE, no write, pready never asserts.
  - rst=0 mid-ACCESS -> pr_data=0, pready=0 immediately; the next transfer after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave memory block.
// Build option: APB_SLAVE_PSLVERR_EN enables out-of-range error responses.
package apb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_WAIT   = 15;

    typedef enum logic {
        APB_S_IDLE   = 1'b0,
        APB_S_ACCESS = 1'b1
    } apb_state_t;

endpackage

// File: rtl/apb_reg_mem.sv
// Register-file backing store with a synchronous write port and a
// read-capture register that clears on reset or on a rejected read.
module apb_reg_mem
    import apb_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    input  logic              rok,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never reset; only a completed write changes it
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Capture read data at the setup edge and hold it until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rok ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave endpoint: memory-backed with programmable wait states.
// Build option: APB_SLAVE_PSLVERR_EN flags addresses >= DEPTH as errors.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] padd,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] pr_data,
    output logic              pready,
    output logic              pslverr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    apb_state_t    state_q;
    apb_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   padd_w;
    logic [IW-1:0] idx;
    logic          addr_ok;
    logic          setup;
    logic          access;

    assign padd_w = 32'(padd);
    assign idx    = IW'(padd_w % 32'(DEPTH));

`ifdef APB_SLAVE_PSLVERR_EN
    assign addr_ok = padd_w < 32'(DEPTH);
`else
    assign addr_ok = 1'b1;
`endif

    assign setup  = (state_q == APB_S_IDLE) && psel && !penable;
    assign access = (state_q == APB_S_ACCESS) && psel && penable;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= APB_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter on setup, leave on completion or deselect
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_S_IDLE: begin
                if (setup) begin
                    state_d = APB_S_ACCESS;
                end
            end
            APB_S_ACCESS: begin
                if (!psel) begin
                    state_d = APB_S_IDLE;
                end else if (access && cnt_q == '0) begin
                    state_d = APB_S_IDLE;
                end
            end
            default: state_d = APB_S_IDLE;
        endcase
    end

    // Completion strobe and error response
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        if (access && cnt_q == '0) begin
            pready = 1'b1;
`ifdef APB_SLAVE_PSLVERR_EN
            pslverr = !addr_ok;
`endif
        end
    end

    // Wait counter: loaded at setup, counts down during access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (setup) begin
            cnt_q <= CW'(WAIT_STATES);
        end else if (access && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    apb_reg_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (pready && pwrite && addr_ok),
        .waddr (idx),
        .wdata (pwdata),
        .re    (setup && !pwrite),
        .raddr (idx),
        .rok   (addr_ok),
        .rdata (pr_data)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 2 wait states).
// Scoreboard queue of expected responses, popped on pready.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit       rd;
        bit       err;
        bit [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       psel [2];
    logic       penable [2];
    logic       pwrite [2];
    logic [7:0] padd [2];
    logic [7:0] pwdata [2];
    logic [7:0] pr_data [2];
    logic       pready [2];
    logic       pslverr [2];

    int ws [2]  = '{0, 2};
    int dep [2] = '{256, 128};

    logic [7:0] mem_m [2][256];
    bit         wr_m [2][256];
    logic [7:0] last [2];
    exp_t       sb_q [$];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .padd(padd[0]), .pwdata(pwdata[0]),
        .pr_data(pr_data[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_slave_mem #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(2)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .padd(padd[1]), .pwdata(pwdata[1]),
        .pr_data(pr_data[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit a_ok(input int d, input logic [7:0] a);
        return ERR_EN ? (int'(a) < dep[d]) : 1'b1;
    endfunction

    function automatic int a_eff(input int d, input logic [7:0] a);
        return int'(a) % dep[d];
    endfunction

    task automatic idle(input int d);
        @(negedge clk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd);
        exp_t e;
        exp_t o;
        bit   ok;
        bit   got;
        int   eff;
        ok     = a_ok(d, a);
        eff    = a_eff(d, a);
        e.rd   = !wr;
        e.err  = ERR_EN && !ok;
        e.data = (!wr && ok) ? mem_m[d][eff] : 8'h00;
        @(negedge clk);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        padd[d]    = a;
        pwdata[d]  = wd;
        sb_q.push_back(e);
        #1 chk("setup_rdy", pready[d], 0);
        @(negedge clk);
        penable[d] = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            #1;
            if (pready[d]) begin
                o = sb_q.pop_front();
                chk("latency", k, ws[d] + 1);
                chk("pslverr", pslverr[d], o.err);
                if (o.rd) begin
                    chk("rdata", pr_data[d], o.data);
                    last[d] = o.data;
                end else begin
                    chk("rd_hold", pr_data[d], last[d]);
                end
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("timeout", got, 1);
        @(posedge clk);
        if (got && wr && ok) begin
            mem_m[d][eff] = wd;
            wr_m[d][eff]  = 1'b1;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
            padd[d] = 0; pwdata[d] = 0; last[d] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_prdata", pr_data[d], 0);
            chk("rst_pready", pready[d], 0);
            chk("rst_pslverr", pslverr[d], 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // zero-wait write then back-to-back read
        xfer(0, 1, 8'hab, 8'hcd);
        xfer(0, 0, 8'hab, 8'h00);
        xfer(0, 1, 8'h00, 8'h11);
        xfer(0, 1, 8'hff, 8'hee);
        xfer(0, 0, 8'hff, 8'h00);
        xfer(0, 0, 8'h00, 8'h00);
        xfer(0, 1, 8'h01, 8'h22);
        idle(0);

        // penable without setup must be ignored
        @(negedge clk);
        psel[0] = 1; penable[0] = 1; pwrite[0] = 1;
        padd[0] = 8'h00; pwdata[0] = 8'h99;
        #1 chk("noset_rdy0", pready[0], 0);
        @(negedge clk);
        #1 chk("noset_rdy1", pready[0], 0);
        idle(0);
        xfer(0, 0, 8'h00, 8'h00);
        idle(0);

        // wait states, out-of-range / wrapped accesses
        xfer(1, 1, 8'h10, 8'h5a);
        xfer(1, 0, 8'h10, 8'h00);
        xfer(1, 1, 8'h4d, 8'h33);
        xfer(1, 1, 8'h20, 8'h44);
        xfer(1, 1, 8'hcd, 8'h77);
        xfer(1, 0, 8'hcd, 8'h00);
        xfer(1, 0, 8'h4d, 8'h00);
        xfer(1, 0, 8'h10, 8'h00);
        idle(1);

        // deselect mid-access: no write, no pready
        @(negedge clk);
        psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
        padd[1] = 8'h20; pwdata[1] = 8'h99;
        @(negedge clk);
        penable[1] = 1;
        #1 chk("abort_rdy_a", pready[1], 0);
        @(negedge clk);
        psel[1] = 0; penable[1] = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("abort_rdy", pready[1], 0);
            @(negedge clk);
        end
        xfer(1, 0, 8'h20, 8'h00);
        idle(1);

        // reset during access
        @(negedge clk);
        psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
        padd[1] = 8'h10; pwdata[1] = 8'ha5;
        @(negedge clk);
        penable[1] = 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_prdata1", pr_data[1], 0);
        chk("rstmid_prdata0", pr_data[0], 0);
        chk("rstmid_pready", pready[1], 0);
        last[0] = 0;
        last[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        psel[1] = 0; penable[1] = 0;
        xfer(1, 0, 8'h10, 8'h00);
        xfer(1, 1, 8'h10, 8'h66);
        xfer(1, 0, 8'h10, 8'h00);
        idle(1);

        // random mixed traffic
        for (int i = 0; i < 24; i++) begin
            int         d;
            bit         wr;
            logic [7:0] a;
            d  = int'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            wr = 1'($urandom_range(0, 1));
            if (!wr && a_ok(d, a) && !wr_m[d][a_eff(d, a)]) begin
                wr = 1'b1;
            end
            xfer(d, wr, a, 8'($urandom_range(0, 255)));
            idle(d);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
